recovery_control: RTL and testbench

RECOVERY_CONTROL -- requirements
Module: recovery_control

---
 rtl/ft_pkg.sv | 18 +
 rtl/replay_counter.sv | 26 ++
 rtl/recovery_control.sv | 141 ++++++++++++++
 tb/tb_recovery_control.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// Shared types and default constants for the fault-tolerance recovery logic.
// Holds the recovery FSM state type and the default parameter values.
package ft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_REPLAY,
        ST_RESUME,
        ST_FAIL
    } recovery_state_t;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_CORES  = 3;
    localparam int DEF_MAX_RETRY  = 3;
    localparam int DEF_CNT_WIDTH  = 8;

endpackage

// File: rtl/replay_counter.sv
// Register-file replay address sequencer: clears to 0, steps by one when enabled.
// Ports: clk, rst_n, clear, enable -> count (current address), last (count at max).
module replay_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == {WIDTH{1'b1}});

endmodule

// File: rtl/recovery_control.sv
// Lock-step error recovery: halts cores, replays the register file, resumes or fails.
// Ports: clk, rst_n, error_i, replay_ready_i -> halt_o, resume_o, replay_valid_o,
//        replay_addr_o, faulty_mask_o, fail_o, error_count_o.
module recovery_control
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_CORES  = DEF_NUM_CORES,
    parameter int MAX_RETRY  = DEF_MAX_RETRY,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CORES-1:0]  error_i,
    input  logic                  replay_ready_i,
    output logic                  halt_o,
    output logic                  resume_o,
    output logic                  replay_valid_o,
    output logic [ADDR_WIDTH-1:0] replay_addr_o,
    output logic [NUM_CORES-1:0]  faulty_mask_o,
    output logic                  fail_o,
    output logic [CNT_WIDTH-1:0]  error_count_o
);

    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

    recovery_state_t state, state_next;

    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [RW-1:0]        retry_q, retry_d;

    logic any_err;
    logic retry_hit;
    logic ctr_clear;
    logic ctr_en;
    logic ctr_last;

    assign any_err   = |error_i;
    // Another replay error would use up the last allowed attempt.
    assign retry_hit = (int'(retry_q) + 1 >= MAX_RETRY);

    replay_counter #(
        .WIDTH (ADDR_WIDTH)
    ) u_replay_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (ctr_clear),
        .enable (ctr_en),
        .count  (replay_addr_o),
        .last   (ctr_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state   <= state_next;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        state_next = state;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        ctr_clear  = 1'b0;
        ctr_en     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (any_err) begin
                    state_next = ST_HALT;
                    mask_d     = error_i;
                    retry_d    = '0;
                    if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_HALT: begin
                state_next = ST_REPLAY;
                ctr_clear  = 1'b1;
                mask_d     = mask_q | error_i;
            end
            ST_REPLAY: begin
                // An error wins over a handshake in the same cycle.
                if (any_err) begin
                    mask_d    = mask_q | error_i;
                    ctr_clear = 1'b1;
                    if (retry_hit) begin
                        state_next = ST_FAIL;
                    end else begin
                        retry_d    = retry_q + 1'b1;
                        state_next = ST_HALT;
                    end
                end else if (replay_ready_i) begin
                    if (ctr_last) begin
                        state_next = ST_RESUME;
                        ctr_clear  = 1'b1;
                    end else begin
                        ctr_en = 1'b1;
                    end
                end
            end
            ST_RESUME: begin
                retry_d = '0;
                if (any_err) begin
                    state_next = ST_HALT;
                    mask_d     = error_i;
                    if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_next = ST_IDLE;
                    mask_d     = '0;
                end
            end
            ST_FAIL: begin
                state_next = ST_FAIL;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign halt_o         = (state == ST_HALT) || (state == ST_REPLAY) ||
                            (state == ST_FAIL);
    assign resume_o       = (state == ST_RESUME);
    assign replay_valid_o = (state == ST_REPLAY);
    assign fail_o         = (state == ST_FAIL);
    assign faulty_mask_o  = mask_q;
    assign error_count_o  = cnt_q;

endmodule

// File: tb/tb_recovery_control.sv
// Self-checking bench for recovery_control: directed scenarios plus random traffic
// checked against a behavioural model of the recovery rules.
module tb_recovery_control;

    localparam int AW      = 2;
    localparam int NC      = 3;
    localparam int MR      = 3;
    localparam int CW      = 3;
    localparam int NUM_REG = 2 ** AW;
    localparam int CNT_MAX = 2 ** CW - 1;
    localparam int VW      = 3 + AW + NC + 1 + CW;

    localparam int P_IDLE   = 0;
    localparam int P_HALT   = 1;
    localparam int P_REPLAY = 2;
    localparam int P_RESUME = 3;
    localparam int P_FAIL   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NC-1:0] error_i = '0;
    logic          replay_ready_i = 1'b0;
    logic          halt_o;
    logic          resume_o;
    logic          replay_valid_o;
    logic [AW-1:0] replay_addr_o;
    logic [NC-1:0] faulty_mask_o;
    logic          fail_o;
    logic [CW-1:0] error_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    int            m_ph;
    logic [NC-1:0] m_mask;
    int            m_cnt;
    int            m_retry;
    int            m_addr;

    recovery_control #(
        .ADDR_WIDTH (AW),
        .NUM_CORES  (NC),
        .MAX_RETRY  (MR),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .error_i        (error_i),
        .replay_ready_i (replay_ready_i),
        .halt_o         (halt_o),
        .resume_o       (resume_o),
        .replay_valid_o (replay_valid_o),
        .replay_addr_o  (replay_addr_o),
        .faulty_mask_o  (faulty_mask_o),
        .fail_o         (fail_o),
        .error_count_o  (error_count_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ph    = P_IDLE;
        m_mask  = '0;
        m_cnt   = 0;
        m_retry = 0;
        m_addr  = 0;
    endtask

    task automatic model_new_event(input logic [NC-1:0] e);
        m_ph    = P_HALT;
        m_mask  = e;
        m_retry = 0;
        if (m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic model_step(input logic [NC-1:0] e, input logic r);
        case (m_ph)
            P_IDLE: if (e != 0) model_new_event(e);
            P_HALT: begin
                m_mask = m_mask | e;
                m_ph   = P_REPLAY;
                m_addr = 0;
            end
            P_REPLAY: begin
                if (e != 0) begin
                    m_mask = m_mask | e;
                    m_addr = 0;
                    if (m_retry + 1 >= MR) m_ph = P_FAIL;
                    else begin
                        m_retry++;
                        m_ph = P_HALT;
                    end
                end else if (r) begin
                    if (m_addr == NUM_REG - 1) m_ph = P_RESUME;
                    else m_addr++;
                end
            end
            P_RESUME: begin
                if (e != 0) model_new_event(e);
                else begin
                    m_ph    = P_IDLE;
                    m_mask  = '0;
                    m_retry = 0;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic          h;
        logic [AW-1:0] a;
        h = (m_ph == P_HALT) || (m_ph == P_REPLAY) || (m_ph == P_FAIL);
        a = (m_ph == P_REPLAY) ? AW'(m_addr) : '0;
        return {h, m_ph == P_RESUME, m_ph == P_REPLAY, a, m_mask,
                m_ph == P_FAIL, CW'(m_cnt)};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        logic [AW-1:0] a;
        a = replay_valid_o ? replay_addr_o : '0;
        return {halt_o, resume_o, replay_valid_o, a, faulty_mask_o,
                fail_o, error_count_o};
    endfunction

    task automatic cycle(input logic [NC-1:0] e, input logic r);
        @(negedge clk);
        error_i        = e;
        replay_ready_i = r;
        @(posedge clk);
        model_step(e, r);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        error_i        = '0;
        replay_ready_i = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (dut_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0", dut_vec());
        end
        do_reset();
        cycle('0, 1'b1);
        n_tests++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle got=%h want=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_single_event();
        int halt_cycles = 0;
        int res_pulses = 0;
        int addrs[$];
        logic mask_ok = 1'b1;
        do_reset();
        cycle(3'b010, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (halt_o) halt_cycles++;
            if (resume_o) res_pulses++;
            if (replay_valid_o) begin
                addrs.push_back(int'(replay_addr_o));
                if (faulty_mask_o !== 3'b010) mask_ok = 1'b0;
            end
            cycle('0, 1'b1);
        end
        n_tests++;
        if (halt_cycles != 1 + NUM_REG) begin
            n_fail++;
            $display("FAIL single_halt_len got=%0d want=%0d",
                     halt_cycles, 1 + NUM_REG);
        end
        n_tests++;
        if (addrs.size() != NUM_REG || addrs[0] != 0 || addrs[1] != 1 ||
            addrs[2] != 2 || addrs[3] != 3) begin
            n_fail++;
            $display("FAIL single_addrs got=%p want=0,1,2,3", addrs);
        end
        n_tests++;
        if (res_pulses != 1) begin
            n_fail++;
            $display("FAIL single_resume got=%0d want=1", res_pulses);
        end
        n_tests++;
        if (!mask_ok) begin
            n_fail++;
            $display("FAIL single_mask got=%b want=010", faulty_mask_o);
        end
        n_tests++;
        if (error_count_o !== CW'(1) || halt_o !== 1'b0 || faulty_mask_o !== '0) begin
            n_fail++;
            $display("FAIL single_final got=cnt%0d halt%b mask%b want=cnt1 halt0 mask000",
                     error_count_o, halt_o, faulty_mask_o);
        end
    endtask

    task automatic test_ready_toggle();
        int   accepted[$];
        logic held_ok = 1'b1;
        logic seen_res = 1'b0;
        logic r;
        logic [AW-1:0] prev;
        do_reset();
        cycle(3'b100, 1'b1);
        cycle('0, 1'b1);
        for (int i = 0; i < 20 && !seen_res; i++) begin
            r = (i % 2 == 0);
            prev = replay_addr_o;
            if (replay_valid_o && r) accepted.push_back(int'(replay_addr_o));
            cycle('0, r);
            if (!r && replay_valid_o && replay_addr_o !== prev) held_ok = 1'b0;
            if (resume_o) seen_res = 1'b1;
        end
        n_tests++;
        if (!held_ok) begin
            n_fail++;
            $display("FAIL toggle_hold got=changed want=held");
        end
        n_tests++;
        if (accepted.size() != NUM_REG || accepted[0] != 0 || accepted[1] != 1 ||
            accepted[2] != 2 || accepted[3] != 3) begin
            n_fail++;
            $display("FAIL toggle_seq got=%p want=0,1,2,3", accepted);
        end
        n_tests++;
        if (!seen_res) begin
            n_fail++;
            $display("FAIL toggle_resume got=none want=pulse");
        end
    endtask

    task automatic test_retry();
        logic seen_res = 1'b0;
        do_reset();
        cycle(3'b010, 1'b1);
        cycle('0, 1'b1);
        cycle('0, 1'b1);
        cycle('0, 1'b1);
        n_tests++;
        if (replay_valid_o !== 1'b1 || replay_addr_o !== AW'(2)) begin
            n_fail++;
            $display("FAIL retry_at2 got=v%b a%0d want=v1 a2",
                     replay_valid_o, replay_addr_o);
        end
        cycle(3'b001, 1'b1);
        n_tests++;
        if (halt_o !== 1'b1 || replay_valid_o !== 1'b0 || faulty_mask_o !== 3'b011) begin
            n_fail++;
            $display("FAIL retry_halt got=h%b v%b m%b want=h1 v0 m011",
                     halt_o, replay_valid_o, faulty_mask_o);
        end
        cycle('0, 1'b1);
        n_tests++;
        if (replay_valid_o !== 1'b1 || replay_addr_o !== '0) begin
            n_fail++;
            $display("FAIL retry_restart got=v%b a%0d want=v1 a0",
                     replay_valid_o, replay_addr_o);
        end
        for (int i = 0; i < 10 && !seen_res; i++) begin
            cycle('0, 1'b1);
            if (resume_o) seen_res = 1'b1;
        end
        n_tests++;
        if (!seen_res || error_count_o !== CW'(1)) begin
            n_fail++;
            $display("FAIL retry_complete got=res%b cnt%0d want=res1 cnt1",
                     seen_res, error_count_o);
        end
    endtask

    task automatic test_fail();
        logic ok = 1'b1;
        do_reset();
        cycle(3'b010, 1'b1);
        for (int k = 0; k < MR; k++) begin
            cycle('0, 1'b1);
            cycle(NC'($urandom_range(1, 7)), 1'b1);
        end
        n_tests++;
        if (fail_o !== 1'b1 || halt_o !== 1'b1 || replay_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fail_enter got=f%b h%b v%b want=f1 h1 v0",
                     fail_o, halt_o, replay_valid_o);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(($urandom_range(0, 1) == 1) ? NC'($urandom_range(1, 7)) : '0,
                  1'($urandom_range(0, 1)));
            if (resume_o || !fail_o || !halt_o || error_count_o !== CW'(1)) ok = 1'b0;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fail_absorb got=f%b h%b r%b cnt%0d want=f1 h1 r0 cnt1",
                     fail_o, halt_o, resume_o, error_count_o);
        end
    endtask

    task automatic test_reset_mid_replay();
        logic seen_res = 1'b0;
        do_reset();
        cycle(3'b001, 1'b1);
        cycle('0, 1'b1);
        cycle('0, 1'b1);
        n_tests++;
        if (replay_addr_o !== AW'(1) || replay_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre got=a%0d v%b want=a1 v1",
                     replay_addr_o, replay_valid_o);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({halt_o, resume_o, replay_valid_o, replay_addr_o, faulty_mask_o,
             fail_o, error_count_o} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async got=h%b v%b a%0d m%b cnt%0d want=all0",
                     halt_o, replay_valid_o, replay_addr_o, faulty_mask_o,
                     error_count_o);
        end
        error_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(3'b100, 1'b1);
        for (int i = 0; i < 10 && !seen_res; i++) begin
            cycle('0, 1'b1);
            if (resume_o) seen_res = 1'b1;
        end
        n_tests++;
        if (!seen_res || error_count_o !== CW'(1) || fail_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_recover got=res%b cnt%0d f%b want=res1 cnt1 f0",
                     seen_res, error_count_o, fail_o);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int ev = 0; ev < CNT_MAX + 3; ev++) begin
            cycle(3'b001, 1'b1);
            for (int i = 0; i < NUM_REG + 2; i++) cycle('0, 1'b1);
        end
        n_tests++;
        if (error_count_o !== CW'(CNT_MAX)) begin
            n_fail++;
            $display("FAIL saturate got=%0d want=%0d", error_count_o, CNT_MAX);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cycle(3'b010, 1'b1);
        for (int i = 0; i < NUM_REG + 1; i++) cycle('0, 1'b1);
        n_tests++;
        if (resume_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_resume got=%b want=1", resume_o);
        end
        cycle(3'b100, 1'b1);
        n_tests++;
        if (dut_vec() !== exp_vec() || halt_o !== 1'b1 || faulty_mask_o !== 3'b100 ||
            error_count_o !== CW'(2)) begin
            n_fail++;
            $display("FAIL b2b_new_event got=%h want=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int errs = 0;
        logic [NC-1:0] e;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m_ph == P_FAIL && $urandom_range(0, 15) == 0) do_reset();
            e = ($urandom_range(0, 7) == 0) ? NC'($urandom_range(1, 7)) : '0;
            cycle(e, 1'($urandom_range(0, 1)));
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle%0d got=%h want=%h",
                             i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_ready_toggle();
        test_retry();
        test_fail();
        test_reset_mid_replay();
        test_saturate();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
